// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit driving a single data bus, with sub-word read-modify-write and bus timeout
module mem_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        r_mem_enable_i,
    input  logic        w_mem_enable_i,
    input  logic [31:0] r_mem_addr_i,
    input  logic [31:0] w_mem_addr_i,
    input  logic [31:0] w_mem_data_i,
    input  logic [2:0]  data_type_i,
    input  logic        mem_w_reg_enable_i,
    input  logic [4:0]  w_reg_addr_i,
    output logic [31:0] bus_addr_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic        w_reg_enable_o,
    output logic [4:0]  w_reg_addr_o,
    output logic [31:0] w_reg_data_o,
    output logic        stall_o,
    output logic        misalign_o,
    output logic        bus_err_o
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, RD, WR, WB} state_t;

    state_t        state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   word_q, word_d;
    logic [2:0]    type_q, type_d;
    logic          store_q, store_d;
    logic          wen_q, wen_d;
    logic [4:0]    rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mis_q, mis_d;
    logic          err_q, err_d;

    logic        req_in, in_byte, in_half, in_word, misaligned, accept, timeout, sgn;
    logic [31:0] in_addr, mask, merged, lane, load_val;
    logic [4:0]  sh;

    // request decode, sub-word lane merge for stores and lane extraction for loads
    always_comb begin
        req_in     = r_mem_enable_i | w_mem_enable_i;
        in_addr    = w_mem_enable_i ? w_mem_addr_i : r_mem_addr_i;
        in_byte    = data_type_i[1:0] == 2'b01;
        in_half    = data_type_i[1:0] == 2'b10;
        in_word    = !in_byte && !in_half;
        misaligned = (in_half && in_addr[0]) || (in_word && |in_addr[1:0]);
        accept     = state_q == IDLE && req_in && !misaligned;
        timeout    = cnt_q == CW'(TIMEOUT_CYCLES - 1);
        sh         = {addr_q[1:0], 3'b000};
        mask       = type_q[1:0] == 2'b01 ? 32'h0000_00FF << sh :
                     type_q[1:0] == 2'b10 ? 32'h0000_FFFF << sh : 32'hFFFF_FFFF;
        merged     = (bus_rdata_i & ~mask) | ((word_q << sh) & mask);
        lane       = word_q >> sh;
        sgn        = !type_q[2];
        load_val   = type_q[1:0] == 2'b01 ? {{24{sgn & lane[7]}}, lane[7:0]} :
                     type_q[1:0] == 2'b10 ? {{16{sgn & lane[15]}}, lane[15:0]} : word_q;
    end

    // next-state logic: accept in IDLE, read then write for sub-word stores, timeout per bus phase
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        word_d  = word_q;
        type_d  = type_q;
        store_d = store_q;
        wen_d   = wen_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        mis_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                mis_d = req_in && misaligned;
                if (accept) begin
                    addr_d  = in_addr;
                    word_d  = w_mem_data_i;
                    type_d  = data_type_i;
                    store_d = w_mem_enable_i;
                    wen_d   = mem_w_reg_enable_i;
                    rd_d    = w_reg_addr_i;
                    cnt_d   = '0;
                    state_d = (w_mem_enable_i && in_word) ? WR : RD;
                end
            end
            RD: begin
                if (bus_ack_i) begin
                    word_d  = store_q ? merged : bus_rdata_i;
                    cnt_d   = '0;
                    state_d = store_q ? WR : WB;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WR: begin
                if (bus_ack_i) begin
                    state_d = IDLE;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state and latched transaction fields
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            word_q  <= '0;
            type_q  <= '0;
            store_q <= 1'b0;
            wen_q   <= 1'b0;
            rd_q    <= '0;
            cnt_q   <= '0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            type_q  <= type_d;
            store_q <= store_d;
            wen_q   <= wen_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
            err_q   <= err_d;
        end
    end

    assign bus_req_o      = state_q == RD || state_q == WR;
    assign bus_we_o       = state_q == WR;
    assign bus_addr_o     = bus_req_o ? {addr_q[31:2], 2'b00} : 32'h0;
    assign bus_wdata_o    = bus_we_o ? word_q : 32'h0;
    assign w_reg_enable_o = state_q == WB && wen_q && |rd_q;
    assign w_reg_addr_o   = state_q == WB ? rd_q : 5'h0;
    assign w_reg_data_o   = state_q == WB ? load_val : 32'h0;
    assign stall_o        = bus_req_o || accept;
    assign misalign_o     = mis_q;
    assign bus_err_o      = err_q;
endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum number of cycles to wait for bus_ack_i per bus phase.
REQ-002 Single clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 r_mem_enable_i  in  1  execute stage requests a memory read (load, or the read half of a store).
REQ-006 w_mem_enable_i  in  1  execute stage requests a memory write (store).
REQ-007 r_mem_addr_i, w_mem_addr_i  in  32 each  byte addresses from the execute stage.
REQ-008 w_mem_data_i  in  32  store data; bits [7:0] / [15:0] are significant for byte / half stores.
REQ-009 data_type_i  in  3  000 none, 001 byte signed, 010 half signed, 011 word, 101 byte unsigned, 110 half unsigned.
REQ-010 mem_w_reg_enable_i  in  1  load result is to be written to a register.
REQ-011 w_reg_addr_i  in  5  destination register for the load.
REQ-012 bus_addr_o  out  32  word-aligned data-bus address.
REQ-013 bus_req_o, bus_we_o  out  1 each  bus request, and write strobe (1 = write).
REQ-014 bus_wdata_o  out  32  write data; bus_rdata_i  in  32  read data; bus_ack_i  in  1  bus completion.
REQ-015 w_reg_enable_o  out  1, w_reg_addr_o  out  5, w_reg_data_o  out  32: load write-back to the register file.
REQ-016 stall_o  out  1  holds the upstream pipeline.
REQ-017 misalign_o, bus_err_o  out  1 each  single-cycle error pulses.

Function
REQ-018 FSM states: IDLE, RD, WR, WB.
REQ-019 Request acceptance: a request is accepted only in IDLE, when r_mem_enable_i or w_mem_enable_i is 1.
- On acceptance, the block latches the address, data, type and destination fields.
- Inputs are ignored in every other state.
REQ-020 Misalignment check on acceptance:
- A half access with addr[0]=1, or a word access with addr[1:0]!=0, is misaligned.
- A misaligned request pulses misalign_o for 1 cycle, makes no bus access, and the FSM stays in IDLE.
REQ-021 Transitions from IDLE on acceptance:
- Load, or byte/half store: go to RD.
- Word store: go to WR.
REQ-022 RD state:
- bus_req_o=1, bus_we_o=0.
- On bus_ack_i, latch bus_rdata_i.
- Then go to WB for a load, or to WR for a store; a store's WR data merges the new byte/half lane into the latched word.
REQ-023 WR state:
- bus_req_o=1, bus_we_o=1.
- On bus_ack_i, go to IDLE; no write-back occurs.
REQ-024 bus_addr_o is {addr[31:2],2'b00}; bus_addr_o, bus_we_o and bus_wdata_o stay stable while bus_req_o=1, and bus_req_o is held until ack.
REQ-025 WB state lasts exactly 1 cycle and returns to IDLE.
- In WB, w_reg_enable_o = mem_w_reg_enable_q AND (w_reg_addr_q != 0).
- w_reg_data_o is the addressed lane (selected by addr[1:0]), sign- or zero-extended per type.
REQ-026 stall_o = (state is RD or WR) OR (state is IDLE AND a non-misaligned request is accepted); stall_o is 0 in WB.
REQ-027 Load latency: with ack in the first RD cycle, write-back appears 2 cycles after acceptance. Each wait cycle adds 1.
REQ-028 Timeout counter:
- Cleared on entering RD or WR, and increments each cycle without ack.
- On reaching TIMEOUT_CYCLES: pulse bus_err_o for 1 cycle, drop bus_req_o, go to IDLE, no write-back.
REQ-029 bus_ack_i while IDLE or WB is ignored.
REQ-030 Outside WB, w_reg_enable_o=0 and w_reg_data_o=0.

Reset
REQ-031 On a clock edge with rst=1 (including mid-transaction), the block returns to IDLE and clears the timeout counter and all latched fields.
- All outputs read 0 in the following cycle.
- An in-flight bus request is abandoned.

Verification
REQ-032 Signed byte load: load byte signed, addr 0x103, rdata 0x80FF_FF7F, ack in 1st RD cycle -> w_reg_data_o=0xFFFF_FF80, w_reg_enable_o=1 in WB, stall_o high for 2 cycles.
REQ-033 Half store merge: store half, addr 0x202, data 0x1234, rdata 0xAAAA_BBBB -> WR phase bus_wdata_o=0x1234_BBBB, bus_addr_o=0x200, no write-back.
REQ-034 Word store: store word, addr 0x10, data 0xDEAD_BEEF -> no RD phase, single WR with bus_wdata_o=0xDEAD_BEEF; stall_o drops after ack.
REQ-035 Misalignment: load word, addr 0x6 -> misalign_o=1 for 1 cycle, bus_req_o stays 0, stall_o=0.
REQ-036 Timeout: TIMEOUT_CYCLES=4, load with no ack -> bus_err_o pulse after 4 RD cycles, FSM in IDLE, w_reg_enable_o never 1.
REQ-037 Reset mid-transaction: rst asserted in the 2nd RD cycle of a load with ack delayed -> next cycle bus_req_o=0, stall_o=0; a late ack is ignored.
